// File: rtl/uart_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_pkg : state encodings and bit-period derivation for uart_serial_core  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_STOP      = 3'd3,
    RX_WAIT_HIGH = 3'd4
  } rx_state_t;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  function automatic int calc_cycles_per_bit(input int clk_hz, input int bit_rate);
    return clk_hz / bit_rate;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_bit_timer : loadable down-counter, strobes on the last cycle of a load |
// | Revision       : 1.0                                                        |
// +----------------------------------------------------------------------------+
module uart_bit_timer #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_value,
  output logic             o_tick
);

  logic [WIDTH-1:0] r_count;

  // A load of N yields o_tick on the Nth cycle after the load edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (r_count != '0) begin
      r_count <= r_count - WIDTH'(1);
    end
  end

  assign o_tick = (r_count == WIDTH'(1));

endmodule
`default_nettype wire

// File: rtl/uart_serial_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | uart_serial_core : full-duplex 8N1-style UART receiver and transmitter      |
// | Revision         : 1.0                                                      |
// +----------------------------------------------------------------------------+
module uart_serial_core #(
  parameter int CLK_HZ       = 24_000_000,
  parameter int BIT_RATE     = 115200,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  output logic                    uart_rx_break,
  output logic                    uart_rx_valid,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_txd,
  input  logic                    uart_tx_en,
  output logic                    uart_tx_busy,
  input  logic [PAYLOAD_BITS-1:0] uart_tx_data
);
  import uart_pkg::*;

  localparam int c_cycles_per_bit = calc_cycles_per_bit(CLK_HZ, BIT_RATE);
  localparam int c_cnt_w          = $clog2(c_cycles_per_bit) + 1;
  localparam int c_idx_w          = $clog2(PAYLOAD_BITS) + 1;
  localparam logic [c_cnt_w-1:0] c_full_bit  = c_cnt_w'(c_cycles_per_bit);
  localparam logic [c_cnt_w-1:0] c_half_bit  = c_cnt_w'(c_cycles_per_bit / 2);
  localparam logic [c_idx_w-1:0] c_last_idx  = c_idx_w'(PAYLOAD_BITS - 1);
  localparam logic               c_last_stop = (STOP_BITS == 2);

  // ---------------- receiver ----------------
  rx_state_t                r_rx_state;
  logic [1:0]               r_rx_sync;
  logic [PAYLOAD_BITS-1:0]  r_rx_shift;
  logic [PAYLOAD_BITS-1:0]  r_rx_data;
  logic [c_idx_w-1:0]       r_rx_idx;
  logic                     r_rx_valid;
  logic                     r_rx_break;
  logic                     w_rxd;
  logic                     w_rx_tick;
  logic                     w_rx_load;
  logic [c_cnt_w-1:0]       w_rx_load_value;

  assign w_rxd = r_rx_sync[1];

  // Half period from the start edge, then full periods land each sample mid-bit.
  assign w_rx_load = ((r_rx_state == RX_IDLE) && !w_rxd) ||
                     (w_rx_tick && (((r_rx_state == RX_START) && !w_rxd) ||
                                    (r_rx_state == RX_DATA)));
  assign w_rx_load_value = (r_rx_state == RX_IDLE) ? c_half_bit : c_full_bit;

  uart_bit_timer #(.WIDTH(c_cnt_w)) u_rx_timer (
    .clk          (clk),
    .resetn       (resetn),
    .i_load       (w_rx_load),
    .i_load_value (w_rx_load_value),
    .o_tick       (w_rx_tick)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rx_sync  <= 2'b11;
      r_rx_state <= RX_IDLE;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_rx_idx   <= '0;
      r_rx_valid <= 1'b0;
      r_rx_break <= 1'b0;
    end else begin
      r_rx_sync  <= {r_rx_sync[0], uart_rxd};
      r_rx_valid <= 1'b0;
      r_rx_break <= 1'b0;
      case (r_rx_state)
        RX_IDLE: if (!w_rxd) r_rx_state <= RX_START;
        RX_START: if (w_rx_tick) begin
          if (w_rxd) begin
            r_rx_state <= RX_IDLE;
          end else begin
            r_rx_idx   <= '0;
            r_rx_state <= RX_DATA;
          end
        end
        RX_DATA: if (w_rx_tick) begin
          r_rx_shift <= {w_rxd, r_rx_shift[PAYLOAD_BITS-1:1]};
          r_rx_idx   <= r_rx_idx + c_idx_w'(1);
          if (r_rx_idx == c_last_idx) r_rx_state <= RX_STOP;
        end
        RX_STOP: if (w_rx_tick) begin
          if (w_rxd) begin
            if (uart_rx_en) begin
              r_rx_data  <= r_rx_shift;
              r_rx_valid <= 1'b1;
            end
            r_rx_state <= RX_IDLE;
          end else begin
            // Low stop bit: break if the whole frame was low, otherwise framing error.
            r_rx_break <= (r_rx_shift == '0);
            r_rx_state <= RX_WAIT_HIGH;
          end
        end
        RX_WAIT_HIGH: if (w_rxd) r_rx_state <= RX_IDLE;
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  assign uart_rx_valid = r_rx_valid;
  assign uart_rx_break = r_rx_break;
  assign uart_rx_data  = r_rx_data;

  // ---------------- transmitter ----------------
  tx_state_t                r_tx_state;
  logic [PAYLOAD_BITS-1:0]  r_tx_shift;
  logic [c_idx_w-1:0]       r_tx_idx;
  logic                     r_tx_stop_idx;
  logic                     r_txd;
  logic                     r_tx_busy;
  logic                     w_tx_tick;
  logic                     w_tx_load;

  assign w_tx_load = ((r_tx_state == TX_IDLE) && uart_tx_en) ||
                     (w_tx_tick && !((r_tx_state == TX_STOP) && (r_tx_stop_idx == c_last_stop)));

  uart_bit_timer #(.WIDTH(c_cnt_w)) u_tx_timer (
    .clk          (clk),
    .resetn       (resetn),
    .i_load       (w_tx_load),
    .i_load_value (c_full_bit),
    .o_tick       (w_tx_tick)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_tx_state    <= TX_IDLE;
      r_tx_shift    <= '0;
      r_tx_idx      <= '0;
      r_tx_stop_idx <= 1'b0;
      r_txd         <= 1'b1;
      r_tx_busy     <= 1'b0;
    end else begin
      case (r_tx_state)
        TX_IDLE: if (uart_tx_en) begin
          r_tx_shift <= uart_tx_data;
          r_txd      <= 1'b0;
          r_tx_busy  <= 1'b1;
          r_tx_state <= TX_START;
        end
        TX_START: if (w_tx_tick) begin
          r_txd      <= r_tx_shift[0];
          r_tx_shift <= {1'b0, r_tx_shift[PAYLOAD_BITS-1:1]};
          r_tx_idx   <= '0;
          r_tx_state <= TX_DATA;
        end
        TX_DATA: if (w_tx_tick) begin
          if (r_tx_idx == c_last_idx) begin
            r_txd         <= 1'b1;
            r_tx_stop_idx <= 1'b0;
            r_tx_state    <= TX_STOP;
          end else begin
            r_txd      <= r_tx_shift[0];
            r_tx_shift <= {1'b0, r_tx_shift[PAYLOAD_BITS-1:1]};
            r_tx_idx   <= r_tx_idx + c_idx_w'(1);
          end
        end
        TX_STOP: if (w_tx_tick) begin
          if (r_tx_stop_idx == c_last_stop) begin
            r_tx_busy  <= 1'b0;
            r_tx_state <= TX_IDLE;
          end else begin
            r_tx_stop_idx <= 1'b1;
          end
        end
        default: r_tx_state <= TX_IDLE;
      endcase
    end
  end

  assign uart_txd     = r_txd;
  assign uart_tx_busy = r_tx_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_serial_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_uart_serial_core : frame-level model and directed vectors for the UART   |
// | Revision            : 1.0                                                   |
// +----------------------------------------------------------------------------+
module tb_uart_serial_core;

  localparam int CPB   = 24_000_000 / 115200;
  localparam int FRAME = 10;

  logic       clk          = 1'b0;
  logic       resetn       = 1'b0;
  logic       rxd_drv      = 1'b1;
  logic       loop_en      = 1'b0;
  logic       uart_rx_en   = 1'b1;
  logic       uart_tx_en   = 1'b0;
  logic [7:0] uart_tx_data = 8'h00;
  logic       uart_rxd;
  logic       uart_rx_break;
  logic       uart_rx_valid;
  logic [7:0] uart_rx_data;
  logic       uart_txd;
  logic       uart_tx_busy;

  assign uart_rxd = loop_en ? uart_txd : rxd_drv;

  always #5 clk = ~clk;

  uart_serial_core #(
    .CLK_HZ       (24_000_000),
    .BIT_RATE     (115200),
    .PAYLOAD_BITS (8),
    .STOP_BITS    (1)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .uart_rxd      (uart_rxd),
    .uart_rx_en    (uart_rx_en),
    .uart_rx_break (uart_rx_break),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_data  (uart_rx_data),
    .uart_txd      (uart_txd),
    .uart_tx_en    (uart_tx_en),
    .uart_tx_busy  (uart_tx_busy),
    .uart_tx_data  (uart_tx_data)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_valid = 0;
  int n_break = 0;

  // Expected RX event: a valid byte or a break inside a cycle window.
  typedef struct {
    bit         brk;
    logic [7:0] data;
    int         lo;
    int         hi;
  } ev_t;
  ev_t q[$];
  int  q_rd = 0;

  bit         m_busy    = 1'b0;
  int         m_cnt     = 0;
  logic [9:0] m_frame   = 10'h3ff;
  logic [7:0] m_rx_data = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Transmitter as a frame: 10 bits, each CPB cycles long, from the accepting edge.
  task automatic model_edge();
    if (!resetn) begin
      m_busy    = 1'b0;
      m_cnt     = 0;
      m_rx_data = 8'h00;
    end else if (m_busy) begin
      m_cnt++;
      if (m_cnt == FRAME * CPB) m_busy = 1'b0;
    end else if (uart_tx_en) begin
      m_busy  = 1'b1;
      m_cnt   = 0;
      m_frame = {1'b1, uart_tx_data, 1'b0};
    end
  endtask

  task automatic compare();
    logic exp_txd;
    ev_t  ev;
    exp_txd = m_busy ? m_frame[m_cnt / CPB] : 1'b1;
    chk("txd", uart_txd, exp_txd);
    chk("busy", uart_tx_busy, m_busy);
    if (uart_rx_valid) n_valid++;
    if (uart_rx_break) n_break++;
    if (uart_rx_valid || uart_rx_break) begin
      if (q_rd >= q.size()) begin
        chk("rx_unexpected_event", {uart_rx_break, uart_rx_valid}, 2'b00);
      end else begin
        ev = q[q_rd];
        q_rd++;
        chk("rx_event_kind", {uart_rx_break, uart_rx_valid}, ev.brk ? 2'b10 : 2'b01);
        chk("rx_event_in_window", (cyc >= ev.lo) && (cyc <= ev.hi), 1'b1);
        if (!ev.brk) m_rx_data = ev.data;
      end
    end else if (q_rd < q.size() && cyc > q[q_rd].hi) begin
      chk("rx_event_missing", 1'b0, 1'b1);
      q_rd++;
    end
    chk("rx_data", uart_rx_data, m_rx_data);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
    compare();
  endtask

  // Drive one frame on rxd starting now (a negedge); line sampled from the next edge.
  task automatic rx_send(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    if (uart_rx_en) q.push_back(ev_t'{1'b0, b, cyc + 1976, cyc + 1982});
    for (int i = 0; i < FRAME; i++) begin
      rxd_drv = f[i];
      repeat (CPB) step();
    end
    repeat (CPB) step();
  endtask

  task automatic rx_break_burst();
    q.push_back(ev_t'{1'b1, 8'h00, cyc + 1976, cyc + 1982});
    rxd_drv = 1'b0;
    repeat (12 * CPB) step();
    rxd_drv = 1'b1;
    repeat (2 * CPB) step();
  endtask

  initial begin
    int bc;
    int v0;
    int b0;

    repeat (3) step();
    chk("reset_txd", uart_txd, 1'b1);
    chk("reset_busy", uart_tx_busy, 1'b0);
    chk("reset_valid", uart_rx_valid, 1'b0);
    chk("reset_break", uart_rx_break, 1'b0);
    chk("reset_rx_data", uart_rx_data, 8'h00);
    resetn = 1'b1;
    repeat (5) step();

    // TX 0x55 waveform pinned at hand-picked offsets.
    bc = 0;
    uart_tx_data = 8'h55;
    uart_tx_en   = 1'b1;
    for (int k = 0; k < 2200; k++) begin
      step();
      uart_tx_en = 1'b0;
      if (uart_tx_busy) bc++;
      if (k == 100)  chk("tx55_start_bit", uart_txd, 1'b0);
      if (k == 308)  chk("tx55_bit0", uart_txd, 1'b1);
      if (k == 516)  chk("tx55_bit1", uart_txd, 1'b0);
      if (k == 1768) chk("tx55_bit7", uart_txd, 1'b0);
      if (k == 1972) chk("tx55_stop", uart_txd, 1'b1);
      if (k == 2100) chk("tx55_idle_busy", uart_tx_busy, 1'b0);
    end
    chk("tx55_busy_cycles", bc, 2080);

    // Loopback, two back-to-back frames with en held high.
    loop_en = 1'b1;
    v0 = n_valid;
    b0 = n_break;
    uart_tx_data = 8'h41;
    uart_tx_en   = 1'b1;
    q.push_back(ev_t'{1'b0, 8'h41, cyc + 1977, cyc + 1983});
    step();
    uart_tx_data = 8'hA7;
    for (int k = 0; k < 3000 && uart_tx_busy; k++) step();
    chk("lb_busy_drop", uart_tx_busy, 1'b0);
    q.push_back(ev_t'{1'b0, 8'hA7, cyc + 1977, cyc + 1983});
    step();
    uart_tx_en = 1'b0;
    chk("lb_second_start", uart_tx_busy, 1'b1);
    repeat (4200) step();
    chk("lb_valid_count", n_valid - v0, 2);
    chk("lb_break_count", n_break - b0, 0);
    chk("lb_last_data", uart_rx_data, 8'hA7);
    loop_en = 1'b0;
    repeat (20) step();

    // Break then a normal frame.
    v0 = n_valid;
    b0 = n_break;
    rx_break_burst();
    chk("brk_break_count", n_break - b0, 1);
    chk("brk_valid_count", n_valid - v0, 0);
    rx_send(8'h33);
    chk("brk_then_data", uart_rx_data, 8'h33);

    // Short low glitch is ignored.
    v0 = n_valid;
    b0 = n_break;
    rxd_drv = 1'b0;
    repeat (50) step();
    rxd_drv = 1'b1;
    repeat (3 * CPB) step();
    chk("glitch_no_valid", n_valid - v0, 0);
    chk("glitch_no_break", n_break - b0, 0);
    rx_send(8'h7E);
    chk("glitch_then_data", uart_rx_data, 8'h7E);

    // Receive disabled: frame discarded, data held.
    v0 = n_valid;
    uart_rx_en = 1'b0;
    rx_send(8'h12);
    chk("rxen_off_data_held", uart_rx_data, 8'h7E);
    chk("rxen_off_no_valid", n_valid - v0, 0);
    uart_rx_en = 1'b1;
    rx_send(8'h34);
    chk("rxen_on_data", uart_rx_data, 8'h34);
    chk("rxen_on_valid", n_valid - v0, 1);

    // en pulsed mid-frame with other data must not disturb 0x96.
    uart_tx_data = 8'h96;
    uart_tx_en   = 1'b1;
    for (int k = 0; k < 2200; k++) begin
      step();
      uart_tx_en = 1'b0;
      if (k == 500) begin
        uart_tx_data = 8'hFF;
        uart_tx_en   = 1'b1;
      end
      if (k == 1560) chk("tx96_bit6_kept", uart_txd, 1'b0);
      if (k == 1768) chk("tx96_bit7", uart_txd, 1'b1);
    end
    uart_tx_data = 8'h00;

    // Reset in the middle of a frame.
    uart_tx_data = 8'hC3;
    uart_tx_en   = 1'b1;
    step();
    uart_tx_en = 1'b0;
    repeat (700) step();
    chk("pre_reset_busy", uart_tx_busy, 1'b1);
    #2 resetn = 1'b0;
    #1;
    chk("async_reset_txd", uart_txd, 1'b1);
    chk("async_reset_busy", uart_tx_busy, 1'b0);
    chk("async_reset_rx_data", uart_rx_data, 8'h00);
    repeat (3) step();
    resetn = 1'b1;
    repeat (2 * CPB) step();
    chk("post_reset_txd", uart_txd, 1'b1);
    chk("post_reset_busy", uart_tx_busy, 1'b0);

    chk("rx_events_all_seen", q_rd, q.size());
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
